// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the MIPS pipeline datapath and its sequencer.
// The sequencer takes the slave side; the datapath (or a testbench) takes the master side.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall_id;
  logic             jump_branch;
  logic             jump_target;
  logic             jump_reg;
  logic [31:0]      br_target;
  logic [31:0]      j_target;
  logic [31:0]      jr_pc;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_we;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             en_if;
  logic             flush_id;
  logic             en_id;
  logic             bubble_ex;
  logic             en_ex;
  logic             en_mem;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;
  logic             timeout_err;

  modport master (
    output stall_id, jump_branch, jump_target, jump_reg, br_target, j_target, jr_pc,
           imem_ready, dmem_req, dmem_ready,
    input  pc_we, redirect, redirect_pc, en_if, flush_id, en_id, bubble_ex, en_ex, en_mem,
           state, stall_cycles, redirect_count, timeout_err
  );

  modport slave (
    input  stall_id, jump_branch, jump_target, jump_reg, br_target, j_target, jr_pc,
           imem_ready, dmem_req, dmem_ready,
    output pc_we, redirect, redirect_pc, en_if, flush_id, en_id, bubble_ex, en_ex, en_mem,
           state, stall_cycles, redirect_count, timeout_err
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage MIPS pipeline sequencer: stage enables, bubble/flush, PC redirect with a
// deferred-redirect slot, saturating stall/redirect counters and a memory-wait timeout.
module pipeline_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2
  } state_e;

  localparam int WC_W  = $clog2(TIMEOUT + 2);
  localparam int TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(TIMEOUT);
  localparam logic [WC_W-1:0]  WC_HIT  = WC_W'(TO_M1);

  state_e           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic        dwait_s, iwait_s, taken_s, wait_s;
  logic [31:0] tgt_s;
  logic        pc_we_s, redirect_s, en_if_s, flush_id_s, en_id_s, bubble_ex_s, en_ex_s, en_mem_s;
  logic [31:0] redirect_pc_s;

  // Hazard decode and target selection shared by every priority level.
  always_comb begin
    dwait_s = bus.dmem_req & ~bus.dmem_ready;
    iwait_s = ~bus.imem_ready;
    taken_s = bus.jump_branch | bus.jump_target;
    wait_s  = dwait_s | iwait_s;
    if (bus.jump_reg) begin
      tgt_s = bus.jr_pc;
    end else if (bus.jump_target) begin
      tgt_s = bus.j_target;
    end else begin
      tgt_s = bus.br_target;
    end
  end

  // Priority-ordered stage controls and deferred-redirect bookkeeping.
  always_comb begin
    pc_we_s       = 1'b0;
    redirect_s    = 1'b0;
    redirect_pc_s = 32'd0;
    en_if_s       = 1'b0;
    flush_id_s    = 1'b0;
    en_id_s       = 1'b0;
    bubble_ex_s   = 1'b0;
    en_ex_s       = 1'b0;
    en_mem_s      = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    if (rst) begin
      flush_id_s   = 1'b1;
      bubble_ex_s  = 1'b1;
      pend_valid_d = 1'b0;
      pend_pc_d    = 32'd0;
    end else if (dwait_s) begin
      pend_valid_d = pend_valid_q;
    end else if (bus.stall_id) begin
      en_id_s     = 1'b1;
      bubble_ex_s = 1'b1;
      en_ex_s     = 1'b1;
      en_mem_s    = 1'b1;
    end else if (iwait_s) begin
      // The ID instruction (branch) moves on while fetch waits, so its target is parked.
      en_if_s    = 1'b1;
      flush_id_s = 1'b1;
      en_id_s    = 1'b1;
      en_ex_s    = 1'b1;
      en_mem_s   = 1'b1;
      if (taken_s) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = tgt_s;
      end else begin
        pend_valid_d = pend_valid_q;
      end
    end else begin
      pc_we_s      = 1'b1;
      en_if_s      = 1'b1;
      en_id_s      = 1'b1;
      en_ex_s      = 1'b1;
      en_mem_s     = 1'b1;
      redirect_s   = pend_valid_q | taken_s;
      pend_valid_d = 1'b0;
      if (pend_valid_q) begin
        redirect_pc_s = pend_pc_q;
      end else if (taken_s) begin
        redirect_pc_s = tgt_s;
      end else begin
        redirect_pc_s = 32'd0;
      end
    end
  end

  // Next-state for wait state, counters and the timeout flag.
  always_comb begin
    if (dwait_s) begin
      state_d = ST_DWAIT;
    end else if (iwait_s & ~bus.stall_id) begin
      state_d = ST_IWAIT;
    end else begin
      state_d = ST_RUN;
    end
    if (~rst & ~pc_we_s & (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (pc_we_s & redirect_s & (redirect_count_q != CNT_MAX)) begin
      redirect_count_d = redirect_count_q + CNT_W'(1);
    end else begin
      redirect_count_d = redirect_count_q;
    end
    if (!wait_s) begin
      wait_cnt_d = {WC_W{1'b0}};
    end else if (wait_cnt_q != WC_MAX) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    // wait_cnt_q holds the waits before this cycle, so this cycle is the TIMEOUT-th at TIMEOUT-1.
    if ((TIMEOUT != 0) && wait_s && (wait_cnt_q == WC_HIT)) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      pend_valid_q     <= 1'b0;
      pend_pc_q        <= 32'd0;
      stall_cycles_q   <= {CNT_W{1'b0}};
      redirect_count_q <= {CNT_W{1'b0}};
      wait_cnt_q       <= {WC_W{1'b0}};
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_valid_q     <= pend_valid_d;
      pend_pc_q        <= pend_pc_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
      wait_cnt_q       <= wait_cnt_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign bus.pc_we          = pc_we_s;
  assign bus.redirect       = redirect_s;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.en_if          = en_if_s;
  assign bus.flush_id       = flush_id_s;
  assign bus.en_id          = en_id_s;
  assign bus.bubble_ex      = bubble_ex_s;
  assign bus.en_ex          = en_ex_s;
  assign bus.en_mem         = en_mem_s;
  assign bus.state          = state_q;
  assign bus.stall_cycles   = stall_cycles_q;
  assign bus.redirect_count = redirect_count_q;
  assign bus.timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (TIMEOUT=8, CNT_W=4, TIMEOUT=0) share stimulus.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id, jump_branch, jump_target, jump_reg, imem_ready, dmem_req, dmem_ready;
  logic [31:0] br_target, j_target, jr_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) if_main ();
  pipeline_ctrl_if #(.CNT_W(4))  if_sat ();
  pipeline_ctrl_if #(.CNT_W(16)) if_nto ();

  assign if_main.stall_id = stall_id;    assign if_sat.stall_id = stall_id;    assign if_nto.stall_id = stall_id;
  assign if_main.jump_branch = jump_branch; assign if_sat.jump_branch = jump_branch; assign if_nto.jump_branch = jump_branch;
  assign if_main.jump_target = jump_target; assign if_sat.jump_target = jump_target; assign if_nto.jump_target = jump_target;
  assign if_main.jump_reg = jump_reg;    assign if_sat.jump_reg = jump_reg;    assign if_nto.jump_reg = jump_reg;
  assign if_main.br_target = br_target;  assign if_sat.br_target = br_target;  assign if_nto.br_target = br_target;
  assign if_main.j_target = j_target;    assign if_sat.j_target = j_target;    assign if_nto.j_target = j_target;
  assign if_main.jr_pc = jr_pc;          assign if_sat.jr_pc = jr_pc;          assign if_nto.jr_pc = jr_pc;
  assign if_main.imem_ready = imem_ready; assign if_sat.imem_ready = imem_ready; assign if_nto.imem_ready = imem_ready;
  assign if_main.dmem_req = dmem_req;    assign if_sat.dmem_req = dmem_req;    assign if_nto.dmem_req = dmem_req;
  assign if_main.dmem_ready = dmem_ready; assign if_sat.dmem_ready = dmem_ready; assign if_nto.dmem_ready = dmem_ready;

  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(8))   u_main (.clk(clk), .rst(rst), .bus(if_main.slave));
  pipeline_ctrl #(.CNT_W(4),  .TIMEOUT(256)) u_sat  (.clk(clk), .rst(rst), .bus(if_sat.slave));
  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(0))   u_nto  (.clk(clk), .rst(rst), .bus(if_nto.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_id = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
    br_target = 32'd0; j_target = 32'd0; jr_pc = 32'd0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; idle();
    step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      rst = 1'b1;
      stall_id = 1'($urandom); jump_branch = 1'($urandom); jump_target = 1'($urandom);
      jump_reg = 1'($urandom); br_target = $urandom; j_target = $urandom; jr_pc = $urandom;
      imem_ready = 1'($urandom); dmem_req = 1'($urandom); dmem_ready = 1'($urandom);
      #1;
      checks++; if (if_main.pc_we !== 1'b0) begin errors++; $display("FAIL rst_pc_we got=%0h exp=0", if_main.pc_we); end
      checks++; if (if_main.flush_id !== 1'b1 || if_main.bubble_ex !== 1'b1) begin errors++; $display("FAIL rst_flush_bubble got=%0h%0h exp=11", if_main.flush_id, if_main.bubble_ex); end
      checks++; if ({if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.redirect} !== 5'b00000) begin errors++; $display("FAIL rst_enables got=%0b exp=00000", {if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.redirect}); end
    end
    step(); rst = 1'b0; idle(); #1;
    checks++; if (if_main.state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", if_main.state); end
    checks++; if (if_main.stall_cycles !== 16'd0 || if_main.redirect_count !== 16'd0) begin errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", if_main.stall_cycles, if_main.redirect_count); end
    checks++; if (if_main.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%0h exp=0", if_main.timeout_err); end
    checks++; if ({if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.pc_we} !== 5'b11111) begin errors++; $display("FAIL run_enables got=%0b exp=11111", {if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.pc_we}); end
    checks++; if (if_main.redirect !== 1'b0 || if_main.redirect_pc !== 32'd0 || if_main.flush_id !== 1'b0) begin errors++; $display("FAIL run_no_redirect got=%0h/%0h/%0h exp=0/0/0", if_main.redirect, if_main.redirect_pc, if_main.flush_id); end
  endtask

  task automatic test_load_use();
    do_reset();
    step(); idle(); stall_id = 1'b1; jump_branch = 1'b1; br_target = 32'h40; #1;
    checks++; if (if_main.pc_we !== 1'b0 || if_main.en_if !== 1'b0) begin errors++; $display("FAIL lu_hold got=%0h%0h exp=00", if_main.pc_we, if_main.en_if); end
    checks++; if ({if_main.en_id, if_main.bubble_ex, if_main.en_ex, if_main.en_mem} !== 4'b1111) begin errors++; $display("FAIL lu_bubble got=%0b exp=1111", {if_main.en_id, if_main.bubble_ex, if_main.en_ex, if_main.en_mem}); end
    checks++; if (if_main.redirect !== 1'b0 || if_main.redirect_pc !== 32'd0) begin errors++; $display("FAIL lu_no_redirect got=%0h/%0h exp=0/0", if_main.redirect, if_main.redirect_pc); end
    step(); stall_id = 1'b0; #1;
    checks++; if (if_main.stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_stall_cycles got=%0d exp=1", if_main.stall_cycles); end
    checks++; if (if_main.redirect !== 1'b1 || if_main.redirect_pc !== 32'h40 || if_main.pc_we !== 1'b1) begin errors++; $display("FAIL lu_redirect got=%0h/%0h/%0h exp=1/40/1", if_main.redirect, if_main.redirect_pc, if_main.pc_we); end
    step(); idle(); #1;
    checks++; if (if_main.redirect_count !== 16'd1) begin errors++; $display("FAIL lu_redirect_count got=%0d exp=1", if_main.redirect_count); end
  endtask

  task automatic test_deferred_jr();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); idle();
      imem_ready = 1'b0; jump_target = 1'b1; jump_reg = 1'b1; jr_pc = 32'h1000; j_target = 32'h2000; br_target = 32'h3000;
      #1;
      checks++; if (if_main.flush_id !== 1'b1 || if_main.en_if !== 1'b1 || if_main.pc_we !== 1'b0 || if_main.redirect !== 1'b0) begin errors++; $display("FAIL djr_wait got=%0h%0h%0h%0h exp=1100", if_main.flush_id, if_main.en_if, if_main.pc_we, if_main.redirect); end
    end
    step(); idle(); #1;
    checks++; if (if_main.state !== 2'd2) begin errors++; $display("FAIL djr_state got=%0d exp=2", if_main.state); end
    checks++; if (if_main.redirect !== 1'b1 || if_main.redirect_pc !== 32'h1000) begin errors++; $display("FAIL djr_apply got=%0h/%0h exp=1/1000", if_main.redirect, if_main.redirect_pc); end
    step(); idle(); #1;
    checks++; if (if_main.redirect !== 1'b0 || if_main.state !== 2'd0) begin errors++; $display("FAIL djr_cleared got=%0h/%0d exp=0/0", if_main.redirect, if_main.state); end
    checks++; if (if_main.stall_cycles !== 16'd4 || if_main.redirect_count !== 16'd1) begin errors++; $display("FAIL djr_counters got=%0d/%0d exp=4/1", if_main.stall_cycles, if_main.redirect_count); end
  endtask

  task automatic test_pending_priority();
    do_reset();
    step(); idle(); imem_ready = 1'b0; jump_branch = 1'b1; br_target = 32'h100; #1;
    step(); idle(); jump_target = 1'b1; j_target = 32'h200; #1;
    checks++; if (if_main.redirect !== 1'b1 || if_main.redirect_pc !== 32'h100) begin errors++; $display("FAIL prio_pending got=%0h/%0h exp=1/100", if_main.redirect, if_main.redirect_pc); end
    step(); #1;
    checks++; if (if_main.redirect !== 1'b1 || if_main.redirect_pc !== 32'h200) begin errors++; $display("FAIL prio_back_to_back got=%0h/%0h exp=1/200", if_main.redirect, if_main.redirect_pc); end
  endtask

  task automatic test_dwait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(); idle();
      dmem_req = 1'b1; dmem_ready = 1'b0; stall_id = 1'b1; jump_branch = 1'b1; br_target = 32'h80;
      #1;
      checks++; if ({if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.pc_we, if_main.redirect} !== 6'b000000) begin errors++; $display("FAIL dw_frozen got=%0b exp=000000", {if_main.en_if, if_main.en_id, if_main.en_ex, if_main.en_mem, if_main.pc_we, if_main.redirect}); end
    end
    step(); dmem_ready = 1'b1; #1;
    checks++; if (if_main.state !== 2'd1 || if_main.stall_cycles !== 16'd5) begin errors++; $display("FAIL dw_state_count got=%0d/%0d exp=1/5", if_main.state, if_main.stall_cycles); end
    checks++; if (if_main.en_id !== 1'b1 || if_main.bubble_ex !== 1'b1 || if_main.pc_we !== 1'b0 || if_main.redirect !== 1'b0) begin errors++; $display("FAIL dw_stall_resume got=%0h%0h%0h%0h exp=1100", if_main.en_id, if_main.bubble_ex, if_main.pc_we, if_main.redirect); end
    step(); stall_id = 1'b0; dmem_req = 1'b0; #1;
    checks++; if (if_main.redirect !== 1'b1 || if_main.redirect_pc !== 32'h80 || if_main.stall_cycles !== 16'd6) begin errors++; $display("FAIL dw_redirect got=%0h/%0h/%0d exp=1/80/6", if_main.redirect, if_main.redirect_pc, if_main.stall_cycles); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(); idle(); imem_ready = 1'b0; #1;
      checks++; if (if_main.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got=%0h exp=0 at=%0d", if_main.timeout_err, i); end
    end
    step(); idle(); #1;
    checks++; if (if_main.timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got=%0h exp=1", if_main.timeout_err); end
    step(); #1;
    checks++; if (if_main.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%0h exp=1", if_main.timeout_err); end
    do_reset(); #1;
    checks++; if (if_main.timeout_err !== 1'b0) begin errors++; $display("FAIL to_rst_clear got=%0h exp=0", if_main.timeout_err); end
    for (int i = 0; i < 300; i++) begin
      step(); idle(); imem_ready = 1'b0;
    end
    step(); idle(); #1;
    checks++; if (if_nto.timeout_err !== 1'b0) begin errors++; $display("FAIL to_disabled got=%0h exp=0", if_nto.timeout_err); end
    checks++; if (if_sat.timeout_err !== 1'b1) begin errors++; $display("FAIL to_256 got=%0h exp=1", if_sat.timeout_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(); idle(); stall_id = 1'b1;
    end
    step(); idle(); #1;
    checks++; if (if_sat.stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d exp=15", if_sat.stall_cycles); end
    checks++; if (if_main.stall_cycles !== 16'd20) begin errors++; $display("FAIL wide_stall got=%0d exp=20", if_main.stall_cycles); end
  endtask

  task automatic test_rst_mid_iwait();
    do_reset();
    step(); idle(); imem_ready = 1'b0; jump_branch = 1'b1; br_target = 32'h80;
    step(); idle(); imem_ready = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0; idle(); #1;
    checks++; if (if_main.redirect !== 1'b0 || if_main.redirect_pc !== 32'd0 || if_main.pc_we !== 1'b1) begin errors++; $display("FAIL rst_pending got=%0h/%0h/%0h exp=0/0/1", if_main.redirect, if_main.redirect_pc, if_main.pc_we); end
    checks++; if (if_main.state !== 2'd0 || if_main.redirect_count !== 16'd0) begin errors++; $display("FAIL rst_pending_state got=%0d/%0d exp=0/0", if_main.state, if_main.redirect_count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_deferred_jr();
    test_pending_priority();
    test_dwait();
    test_timeout();
    test_saturation();
    test_rst_mid_iwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Combines the decode load-use stall, decode branch/jump resolution and the instruction/data memory ready signals into per-stage register enables, bubble/flush controls and the PC redirect.
- Holds a deferred redirect when a taken branch or jump resolves while fetch is stalled, and keeps saturating stall/redirect counters and a wait-timeout flag.
- Branch delay slots are architectural and are never flushed by this block.

Parameters:
- CNT_W, 16, width of stall_cycles and redirect_count.
- TIMEOUT, 256, consecutive memory-wait cycles before timeout_err sets; 0 disables the check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall_id  in  1  load-use stall request from decode
- jump_branch  in  1  conditional branch in ID is taken
- jump_target  in  1  ID holds J/JAL/JR/JALR
- jump_reg  in  1  ID jump uses a register target (JR/JALR)
- br_target  in  32  branch target for the ID instruction
- j_target  in  32  J/JAL pseudo-direct target
- jr_pc  in  32  forwarded rs value for JR/JALR
- imem_ready  in  1  instruction fetch completes this cycle
- dmem_req  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data access completes this cycle
- pc_we  out  1  PC register load enable
- redirect  out  1  next PC = redirect_pc (else PC+4)
- redirect_pc  out  32  redirect target
- en_if  out  1  IF/ID register enable
- flush_id  out  1  IF/ID loads NOP (valid only with en_if=1)
- en_id  out  1  ID/EX register enable
- bubble_ex  out  1  ID/EX loads NOP (valid only with en_id=1)
- en_ex  out  1  EX/MEM register enable
- en_mem  out  1  MEM/WB register enable
- state  out  2  registered: 0 RUN, 1 DWAIT, 2 IWAIT
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 outside reset
- redirect_count  out  CNT_W  saturating count of applied redirects
- timeout_err  out  1  sticky wait-timeout flag

Behaviour:
Derived terms
- dwait = dmem_req & ~dmem_ready
- iwait = ~imem_ready
- taken = jump_branch | jump_target
- tgt = jump_reg ? jr_pc : (jump_target ? j_target : br_target)

Combinational controls, evaluated in strict priority order
1. rst: all en_*=0, pc_we=0, redirect=0, flush_id=1, bubble_ex=1.
2. dwait: entire pipe frozen. All en_*=0, pc_we=0, redirect=0; pending is unchanged.
3. stall_id: pc_we=0, en_if=0, en_id=1 with bubble_ex=1, en_ex=en_mem=1. Redirect is suppressed, because the branch re-evaluates next cycle.
4. iwait: pc_we=0, en_if=1 with flush_id=1; en_id/en_ex/en_mem=1 and the ID instruction advances. If taken: pend_valid<=1, pend_pc<=tgt.
5. else: all en_*=1, pc_we=1.
   - redirect = pend_valid | taken.
   - redirect_pc = pend_valid ? pend_pc : tgt; pending has priority.
   - pend_valid<=0.
- Whenever redirect=0, redirect_pc=0.

Sequential state
- state is registered: next = dwait ? DWAIT : (iwait & ~stall_id ? IWAIT : RUN).
- pend_valid/pend_pc are cleared by rst, including mid-wait.
- stall_cycles increments when ~rst & ~pc_we; redirect_count increments when pc_we & redirect. Both saturate at 2^CNT_W-1 and reset to 0.
- wait_cnt counts consecutive cycles with (dwait | iwait) and returns to 0 on any cycle with neither.
- When TIMEOUT≠0 and a cycle is the TIMEOUT-th consecutive wait cycle, timeout_err<=1 and becomes visible the next cycle. It stays set until rst.

Reset values: state=RUN, counters=0, timeout_err=0, pend_valid=0, pend_pc=0.

Latency: redirect is applied in the same cycle as resolution, so the PC loads the target at the next edge. A deferred redirect is applied in the first cycle with imem_ready=1 and no dwait or stall_id.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> pc_we=0, flush_id=1, bubble_ex=1, state=0, counters=0; first cycle after rst with all ready and no hazards -> all en_*=1, pc_we=1.
- Load-use stall: stall_id=1 for 1 cycle with jump_branch=1, br_target=0x40 -> pc_we=0, bubble_ex=1, redirect=0, stall_cycles=1; next cycle stall_id=0 -> redirect=1, redirect_pc=0x40, redirect_count=1.
- Deferred JR: jump_target=jump_reg=1, jr_pc=0x1000 while imem_ready=0 for 4 cycles -> flush_id=1, pc_we=0, state=2; on imem_ready=1 -> redirect=1, redirect_pc=0x1000, pending cleared.
- Data wait priority: dmem_req=1, dmem_ready=0 for 5 cycles with stall_id=1 and taken=1 -> all en_*=0, state=1, stall_cycles=5, no redirect; when dmem_ready=1 -> stall_id handling resumes.
- Timeout: TIMEOUT=8, imem_ready=0 for 8 cycles -> timeout_err=1 the following cycle and remains 1 after imem_ready returns; rst clears it. With TIMEOUT=0, 300 wait cycles -> timeout_err stays 0.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15; rst mid-IWAIT with pending 0x80 -> no redirect after reset.
